gshare_pattern_table: RTL and testbench

GSHARE_PATTERN_TABLE -- requirements
Module: gshare_pattern_table

---
 rtl/gshare_pattern_table.sv | 75 +++++++
 tb/tb_gshare_pattern_table.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pattern_table.sv
// Gshare pattern history table: 16 two-bit saturating counters indexed by
// pc XOR global history, with lookup and misprediction statistics.
module gshare_pattern_table #(
  parameter int PC_LSB = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ghr_value,
  input  logic        lookup_F,
  input  logic [31:0] pc_F,
  output logic        predict_taken_F,
  output logic [3:0]  pred_index_F,
  input  logic        update_E,
  input  logic [3:0]  index_E,
  input  logic        taken_E,
  input  logic        predicted_E,
  output logic        mispredict_E,
  output logic [15:0] lookup_count,
  output logic [15:0] mispredict_count
);

  localparam logic [1:0] WEAK_NT  = 2'b01;
  localparam logic [1:0] STRONG_T = 2'b11;
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [1:0]  counter_q [16];
  logic [15:0] lookup_count_q;
  logic [15:0] mispredict_count_q;

  // Only four pc bits feed the index; fold the rest so they are visibly consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^(pc_F & ~(32'hF << PC_LSB));

  // The table is read asynchronously, so a same-cycle update is not yet visible.
  assign pred_index_F    = pc_F[PC_LSB+3:PC_LSB] ^ ghr_value;
  assign predict_taken_F = lookup_F & counter_q[pred_index_F][1];
  assign mispredict_E    = update_E & (taken_E ^ predicted_E);

  assign lookup_count     = lookup_count_q;
  assign mispredict_count = mispredict_count_q;

  // NOTE: the counter array is a register file, not a RAM macro, so it can and
  // must be reset -- every entry starts at weak not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        counter_q[i] <= WEAK_NT;
      end
    end else if (update_E) begin
      if (taken_E && counter_q[index_E] != STRONG_T) begin
        counter_q[index_E] <= counter_q[index_E] + 2'd1;
      end else if (!taken_E && counter_q[index_E] != STRONG_NT) begin
        counter_q[index_E] <= counter_q[index_E] - 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (lookup_F && lookup_count_q != COUNT_MAX) begin
        lookup_count_q <= lookup_count_q + 16'd1;
      end
      if (mispredict_E && mispredict_count_q != COUNT_MAX) begin
        mispredict_count_q <= mispredict_count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Self-checking bench: a table-of-ints model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_gshare_pattern_table;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ghr_value;
  logic        lookup_F;
  logic [31:0] pc_F;
  logic        predict_taken_F;
  logic [3:0]  pred_index_F;
  logic        update_E;
  logic [3:0]  index_E;
  logic        taken_E;
  logic        predicted_E;
  logic        mispredict_E;
  logic [15:0] lookup_count;
  logic [15:0] mispredict_count;

  int checks_total  = 0;
  int checks_passed = 0;

  // Model state: plain integer counters in 0..3 and unbounded-then-clamped counts.
  int  model_ctr [16];
  int  model_lookups;
  int  model_mispredicts;
  bit  model_valid = 1'b0;

  gshare_pattern_table #(.PC_LSB(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .ghr_value        (ghr_value),
    .lookup_F         (lookup_F),
    .pc_F             (pc_F),
    .predict_taken_F  (predict_taken_F),
    .pred_index_F     (pred_index_F),
    .update_E         (update_E),
    .index_E          (index_E),
    .taken_E          (taken_E),
    .predicted_E      (predicted_E),
    .mispredict_E     (mispredict_E),
    .lookup_count     (lookup_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: apply the rules to the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) model_ctr[i] = 1;
      model_lookups     = 0;
      model_mispredicts = 0;
      model_valid       = 1'b1;
    end else if (model_valid) begin
      if (lookup_F) model_lookups = (model_lookups >= 65535) ? 65535 : model_lookups + 1;
      if (update_E && (taken_E != predicted_E))
        model_mispredicts = (model_mispredicts >= 65535) ? 65535 : model_mispredicts + 1;
      if (update_E) begin
        if (taken_E) model_ctr[index_E] = (model_ctr[index_E] >= 3) ? 3 : model_ctr[index_E] + 1;
        else         model_ctr[index_E] = (model_ctr[index_E] <= 0) ? 0 : model_ctr[index_E] - 1;
      end
    end
  end

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (model_valid) begin
      int idx;
      idx = ((pc_F >> 2) & 32'hF) ^ ghr_value;
      check("model_index", {28'd0, pred_index_F}, idx);
      check("model_predict", {31'd0, predict_taken_F}, (lookup_F && model_ctr[idx] >= 2) ? 1 : 0);
      check("model_mispredict", {31'd0, mispredict_E}, (update_E && (taken_E != predicted_E)) ? 1 : 0);
      check("model_lookup_count", {16'd0, lookup_count}, model_lookups);
      check("model_mispredict_count", {16'd0, mispredict_count}, model_mispredicts);
    end
  end

  initial begin
    reset = 1'b1; ghr_value = '0; lookup_F = 1'b0; pc_F = '0;
    update_E = 1'b1; index_E = 4'd4; taken_E = 1'b1; predicted_E = 1'b0;
    tick(); tick();
    reset = 1'b0; update_E = 1'b0;
    check("reset_lookup_count", {16'd0, lookup_count}, 32'd0);
    check("reset_mispredict_count", {16'd0, mispredict_count}, 32'd0);

    // First lookup after reset: index 4, weak not-taken.
    lookup_F = 1'b1; pc_F = 32'h0000_0010; ghr_value = 4'd0;
    #2;
    check("first_index", {28'd0, pred_index_F}, 32'd4);
    check("first_predict", {31'd0, predict_taken_F}, 32'd0);
    tick();
    check("first_lookup_count", {16'd0, lookup_count}, 32'd1);
    lookup_F = 1'b0;
    #2;
    check("no_lookup_predict", {31'd0, predict_taken_F}, 32'd0);

    // Train entry 4 three times toward taken: 01 -> 10 -> 11 -> 11.
    update_E = 1'b1; index_E = 4'd4; taken_E = 1'b1; predicted_E = 1'b0;
    repeat (3) tick();
    update_E = 1'b0;
    check("train_mispredict_count", {16'd0, mispredict_count}, 32'd3);
    lookup_F = 1'b1;
    #2;
    check("trained_predict", {31'd0, predict_taken_F}, 32'd1);

    // Aliasing: pc 0x14 with history 0001 lands on entry 4.
    pc_F = 32'h0000_0014; ghr_value = 4'b0001;
    #2;
    check("alias_index", {28'd0, pred_index_F}, 32'd4);
    check("alias_predict", {31'd0, predict_taken_F}, 32'd1);
    tick();
    lookup_F = 1'b0;

    // Fresh table for the read-before-write case.
    reset = 1'b1; tick(); reset = 1'b0;
    lookup_F = 1'b1; pc_F = 32'h0000_0010; ghr_value = 4'd0;
    update_E = 1'b1; index_E = 4'd4; taken_E = 1'b1; predicted_E = 1'b0;
    #2;
    check("rbw_same_cycle", {31'd0, predict_taken_F}, 32'd0);
    tick();
    update_E = 1'b0;
    #2;
    check("rbw_next_cycle", {31'd0, predict_taken_F}, 32'd1);

    // Mispredict flagged only while update_E is high.
    lookup_F = 1'b0;
    update_E = 1'b1; index_E = 4'd4; taken_E = 1'b0; predicted_E = 1'b1;
    #2;
    check("mispredict_flag", {31'd0, mispredict_E}, 32'd1);
    tick();
    check("mispredict_count_inc", {16'd0, mispredict_count}, 32'd2);
    update_E = 1'b0;
    #2;
    check("no_update_no_mispredict", {31'd0, mispredict_E}, 32'd0);
    tick();

    // Directed training pattern across entries; the model checks every cycle,
    // including decrement saturation and untouched neighbours.
    for (int i = 0; i < 48; i++) begin
      update_E    = (i % 5) != 4;
      index_E     = 4'((i * 7) % 16);
      taken_E     = (i % 3) == 0;
      predicted_E = (i % 2) == 0;
      lookup_F    = (i % 4) != 1;
      pc_F        = 32'(i * 12);
      ghr_value   = 4'(i ^ (i >> 2));
      tick();
    end
    update_E = 1'b1; index_E = 4'd9; taken_E = 1'b0; predicted_E = 1'b0;
    repeat (3) tick();
    update_E = 1'b0; lookup_F = 1'b1; pc_F = 32'h0000_0024; ghr_value = 4'd0;
    #2;
    check("saturated_nt_predict", {31'd0, predict_taken_F}, 32'd0);
    tick();

    // Lookup counter saturation.
    reset = 1'b1; tick(); reset = 1'b0;
    lookup_F = 1'b1; pc_F = 32'h0; ghr_value = 4'd0;
    repeat (65534) tick();
    check("lookup_count_fffe", {16'd0, lookup_count}, 32'h0000_FFFE);
    repeat (3) tick();
    check("lookup_count_sat", {16'd0, lookup_count}, 32'h0000_FFFF);

    // Train entry 3, then reset with a simultaneous update: everything back to 01.
    lookup_F = 1'b0;
    update_E = 1'b1; index_E = 4'd3; taken_E = 1'b1; predicted_E = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; update_E = 1'b0;
    check("reset_lookup_count_2", {16'd0, lookup_count}, 32'd0);
    check("reset_mispredict_count_2", {16'd0, mispredict_count}, 32'd0);
    lookup_F = 1'b1; ghr_value = 4'd0;
    for (int i = 0; i < 16; i++) begin
      pc_F = 32'(i << 2);
      #1;
      check("post_reset_entry", {31'd0, predict_taken_F}, 32'd0);
    end
    update_E = 1'b1; index_E = 4'd3; taken_E = 1'b1;
    tick();
    update_E = 1'b0; pc_F = 32'h0000_000C;
    #2;
    check("post_reset_one_step", {31'd0, predict_taken_F}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
